// File: rtl/stump_alu_pipe.sv
// Registered Stump ALU with valid/ready handshake and an internal NZVC flag register.
// Define STUMP_ALU_MUL_EN to add the iterative shift-add multiplier on func 110.
module stump_alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_A,
    input  logic [WIDTH-1:0] operand_B,
    input  logic [2:0]       func,
    input  logic             c_in,
    input  logic             csh,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags_out
);
    localparam logic [2:0] F_ADD = 3'b000;
    localparam logic [2:0] F_ADC = 3'b001;
    localparam logic [2:0] F_SUB = 3'b010;
    localparam logic [2:0] F_SBC = 3'b011;
    localparam logic [2:0] F_AND = 3'b100;
    localparam logic [2:0] F_OR  = 3'b101;

    logic [WIDTH-1:0] result_reg;
    logic [3:0]       flags_reg;
    logic             out_valid_reg;
    logic             accept;
    logic             sc_load;

    // Single-cycle datapath
    logic [WIDTH-1:0] op_b;
    logic             carry0;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sc_result;
    logic             sc_v;
    logic             sc_c;
    logic [3:0]       sc_flags;

    always_comb begin
        op_b   = operand_B;
        carry0 = 1'b0;
        case (func)
            F_ADC:   carry0 = c_in;
            F_SUB:   begin op_b = ~operand_B; carry0 = 1'b1; end
            F_SBC:   begin op_b = ~operand_B; carry0 = c_in; end
            default: carry0 = 1'b0;
        endcase
        sum = {1'b0, operand_A} + {1'b0, op_b} + {{WIDTH{1'b0}}, carry0};

        sc_result = operand_B;
        sc_v      = 1'b0;
        sc_c      = csh;
        case (func)
            F_ADD, F_ADC, F_SUB, F_SBC: begin
                sc_result = sum[WIDTH-1:0];
                // Using the possibly-inverted B covers both add and subtract overflow
                sc_v = (operand_A[WIDTH-1] == op_b[WIDTH-1]) &&
                       (sum[WIDTH-1] != operand_A[WIDTH-1]);
                sc_c = sum[WIDTH];
            end
            F_AND:   sc_result = operand_A & operand_B;
            F_OR:    sc_result = operand_A | operand_B;
            default: sc_result = operand_B;
        endcase
        sc_flags = {sc_result[WIDTH-1], (sc_result == '0), sc_v, sc_c};
    end

    assign accept = in_valid && in_ready;

`ifdef STUMP_ALU_MUL_EN
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, MUL} state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic [2*WIDTH-1:0]     acc_reg;
    logic [2*WIDTH-1:0]     mcand_reg;
    logic [WIDTH-1:0]       mplr_reg;
    logic                   mul_sf_reg;
    logic [2*WIDTH-1:0]     acc_next;
    logic                   mul_start;
    logic                   mul_done;
    logic [3:0]             mul_flags;

    assign mul_start = accept && (func == 3'b110);
    assign mul_done  = (state_reg == MUL) && (cnt_reg == CNT_W'(WIDTH - 1));
    assign sc_load   = accept && (func != 3'b110);
    assign acc_next  = acc_reg + (mplr_reg[0] ? mcand_reg : '0);
    assign mul_flags = {acc_next[WIDTH-1], (acc_next[WIDTH-1:0] == '0), 1'b0,
                        |acc_next[2*WIDTH-1:WIDTH]};
    assign in_ready  = !rst && (state_reg == IDLE) && (!out_valid_reg || out_ready);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (mul_start) state_next = MUL;
            MUL:     if (mul_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplr_reg   <= '0;
            mul_sf_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (mul_start) begin
                cnt_reg    <= '0;
                acc_reg    <= '0;
                mcand_reg  <= {{WIDTH{1'b0}}, operand_A};
                mplr_reg   <= operand_B;
                mul_sf_reg <= set_flags;
            end else if (state_reg == MUL) begin
                cnt_reg   <= cnt_reg + 1'b1;
                acc_reg   <= acc_next;
                mcand_reg <= mcand_reg << 1;
                mplr_reg  <= mplr_reg >> 1;
            end
        end
    end
`else
    assign sc_load  = accept;
    assign in_ready = !rst && (!out_valid_reg || out_ready);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            result_reg    <= '0;
            flags_reg     <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (out_ready) out_valid_reg <= 1'b0;
            if (sc_load) begin
                result_reg    <= sc_result;
                out_valid_reg <= 1'b1;
                if (set_flags) flags_reg <= sc_flags;
            end
`ifdef STUMP_ALU_MUL_EN
            if (mul_done) begin
                result_reg    <= acc_next[WIDTH-1:0];
                out_valid_reg <= 1'b1;
                if (mul_sf_reg) flags_reg <= mul_flags;
            end
`endif
        end
    end

    assign result    = result_reg;
    assign flags_out = flags_reg;
    assign out_valid = out_valid_reg;
endmodule

// File: tb/tb_stump_alu_pipe.sv
// Directed-vector bench for stump_alu_pipe (WIDTH=16): flag table, backpressure,
// reset behaviour and, with STUMP_ALU_MUL_EN, the iterative multiply.
module tb_stump_alu_pipe;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  operand_A;
    logic [W-1:0]  operand_B;
    logic [2:0]    func;
    logic          c_in;
    logic          csh;
    logic          set_flags;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [3:0]    flags_out;

    int total = 0;
    int bad   = 0;

    stump_alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .operand_A(operand_A), .operand_B(operand_B), .func(func),
        .c_in(c_in), .csh(csh), .set_flags(set_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags_out(flags_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   func;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c_in;
        logic         csh;
        logic         sf;
        logic [W-1:0] exp_result;
        logic [3:0]   exp_flags;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic cs, input logic sf);
        in_valid  = 1'b1;
        func      = f;
        operand_A = a;
        operand_B = b;
        c_in      = ci;
        csh       = cs;
        set_flags = sf;
    endtask

    // Called just after a negedge: present op, take one edge, check at next negedge
    task automatic run_vec(input vec_t v);
        drive(v.func, v.a, v.b, v.c_in, v.csh, v.sf);
        chk("in_ready_before", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("result", 32'(result), 32'(v.exp_result));
        chk("flags", 32'(flags_out), 32'(v.exp_flags));
        $display("op f=%0d a=%h b=%h sf=%0d -> result=%h flags=%b (want %h %b)",
                 v.func, v.a, v.b, v.sf, result, flags_out, v.exp_result, v.exp_flags);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{3'b000, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 4'b1010};
        vecs[1]  = '{3'b010, 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b0101};
        vecs[2]  = '{3'b100, 16'hF0F0, 16'h0FF0, 1'b0, 1'b1, 1'b0, 16'h00F0, 4'b0101};
        vecs[3]  = '{3'b010, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1, 16'hFFFF, 4'b1000};
        vecs[4]  = '{3'b001, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 4'b0101};
        vecs[5]  = '{3'b011, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h7FFF, 4'b0011};
        vecs[6]  = '{3'b101, 16'h1200, 16'h0034, 1'b0, 1'b0, 1'b1, 16'h1234, 4'b0000};
        vecs[7]  = '{3'b111, 16'h5555, 16'h8001, 1'b0, 1'b1, 1'b1, 16'h8001, 4'b1001};
        vecs[8]  = '{3'b000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'hFFFE, 4'b1001};
        vecs[9]  = '{3'b011, 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b1, 16'hFFFF, 4'b1000};
        vecs[10] = '{3'b000, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b0111};
        vecs[11] = '{3'b101, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 4'b0111};

        rst = 1'b1;
        out_ready = 1'b1;
        drive(3'b000, '0, '0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'(flags_out), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        #1 chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

`ifndef STUMP_ALU_MUL_EN
        // Without the multiplier, func 110 is a single-cycle MOVB
        begin
            vec_t mv;
            mv = '{3'b110, 16'h1111, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b0100};
            run_vec(mv);
        end
`endif

        // Output drains when nothing new loads
        @(posedge clk);
        @(negedge clk);
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        // Backpressure: second op must wait for out_ready
        out_ready = 1'b0;
        drive(3'b000, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1 drive(3'b000, 16'h0010, 16'h0014, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_result_hold", 32'(result), 32'h3);
            chk("bp_flags_hold", 32'(flags_out), 32'b0000);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        $display("backpressure held result=%h", result);
        out_ready = 1'b1;
        #1 chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_valid", 32'(out_valid), 32'd1);
        chk("bp_second_result", 32'(result), 32'h24);
        @(posedge clk);
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);
        $display("backpressure second result done");

`ifdef STUMP_ALU_MUL_EN
        begin
            logic [W-1:0] ma[2];
            logic [W-1:0] mb[2];
            logic [W-1:0] mr[2];
            logic [3:0]   mf[2];
            ma[0] = 16'h0100; mb[0] = 16'h0100; mr[0] = 16'h0000; mf[0] = 4'b0101;
            ma[1] = 16'h0003; mb[1] = 16'h0005; mr[1] = 16'h000F; mf[1] = 4'b0000;
            for (int m = 0; m < 2; m++) begin
                drive(3'b110, ma[m], mb[m], 1'b0, 1'b0, 1'b1);
                @(posedge clk);
                #1 in_valid = 1'b0;
                for (int k = 1; k <= W; k++) begin
                    @(negedge clk);
                    chk("mul_busy_in_ready", 32'(in_ready), 32'd0);
                    chk("mul_busy_out_valid", 32'(out_valid), 32'd0);
                end
                @(negedge clk);
                chk("mul_out_valid", 32'(out_valid), 32'd1);
                chk("mul_result", 32'(result), 32'(mr[m]));
                chk("mul_flags", 32'(flags_out), 32'(mf[m]));
                $display("mul %h*%h -> %h flags=%b", ma[m], mb[m], result, flags_out);
            end
        end
`endif

        // Reset with live state: load nonzero result/flags, optionally start a MUL
        drive(3'b000, 16'h8000, 16'h8001, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_flags", 32'(flags_out), 32'b0011);
`ifdef STUMP_ALU_MUL_EN
        drive(3'b110, 16'h00FF, 16'h00FF, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
`endif
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst2_out_valid", 32'(out_valid), 32'd0);
        chk("rst2_result", 32'(result), 32'd0);
        chk("rst2_flags", 32'(flags_out), 32'd0);
        chk("rst2_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1 chk("rst2_in_ready_after", 32'(in_ready), 32'd1);
        repeat (W + 2) @(posedge clk);
        @(negedge clk);
        chk("rst2_no_result", 32'(out_valid), 32'd0);
        $display("reset sequence done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
